// File: rtl/butterfly_ctrl_pkg.sv
// butterfly_ctrl_pkg: shared NTT constants, FSM states and the write-back slot type.
package butterfly_ctrl_pkg;
  localparam int N = 256;
  localparam int Q = 3329;
  localparam int CW = 12;
  localparam int AW = 8;
  localparam int TW = 7;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;
  typedef struct packed {
    logic vld;
    logic last;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } wr_slot_t;
endpackage

// File: rtl/bf_addr_gen.sv
// bf_addr_gen: maps (layer, issue index, mode) to the butterfly's RAM addresses and twiddle index.
module bf_addr_gen import butterfly_ctrl_pkg::*; (
  input  logic [2:0]    layer,
  input  logic [6:0]    idx,
  input  logic          inv,
  output logic [AW-1:0] a,
  output logic [AW-1:0] b,
  output logic [TW-1:0] tw
);
  logic [2:0] s;
  logic [8:0] len;
  logic [6:0] msk;
  logic [6:0] g;
  assign s = inv ? layer + 3'd1 : 3'd7 - layer;
  assign len = 9'd1 << s;
  assign msk = 7'(len - 9'd1);
  assign g = idx >> s;
  // g*len is idx with its offset bits cleared, so doubling it gives g*2*len
  assign a = {idx & ~msk, 1'b0} | {1'b0, idx & msk};
  assign b = a + 8'(len);
  assign tw = 7'(inv ? (9'd256 >> s) - 9'd1 - {2'b0, g} : (9'd128 >> s) + {2'b0, g});
endmodule

// File: rtl/butterfly_ctrl.sv
// butterfly_ctrl: sequences the 7 NTT layers over a dual-port coefficient RAM and an external
// pipelined butterfly, carrying write-back addresses in a latency-matched shift register.
module butterfly_ctrl import butterfly_ctrl_pkg::*; #(
  parameter int LAT_CT = 4,
  parameter int LAT_GS = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          inv,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  input  logic [CW-1:0] rd_data_a,
  input  logic [CW-1:0] rd_data_b,
  output logic [TW-1:0] tw_addr,
  input  logic [CW-1:0] tw_data,
  output logic          bf_CT,
  output logic [CW-1:0] bf_A,
  output logic [CW-1:0] bf_B,
  output logic [CW-1:0] bf_W,
  input  logic [CW-1:0] bf_E,
  input  logic [CW-1:0] bf_O,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr_a,
  output logic [AW-1:0] wr_addr_b,
  output logic [CW-1:0] wr_data_a,
  output logic [CW-1:0] wr_data_b
);
  localparam int DEPTH = (LAT_CT > LAT_GS ? LAT_CT : LAT_GS) + 1;
  state_t state;
  logic [2:0] layer;
  logic [6:0] idx;
  logic [AW-1:0] ga, gb;
  logic [TW-1:0] gtw;
  wr_slot_t [DEPTH-1:0] sr;
  wr_slot_t tap;

  bf_addr_gen u_gen (.layer(layer), .idx(idx), .inv(~bf_CT), .a(ga), .b(gb), .tw(gtw));

  assign rd_en = state == S_ISSUE;
  assign rd_addr_a = rd_en ? ga : '0;
  assign rd_addr_b = rd_en ? gb : '0;
  assign tw_addr = rd_en ? gtw : '0;
  // stage 0 marks the cycle in which the RAM/ROM data of an issue is on the bus
  assign bf_A = sr[0].vld ? rd_data_a : '0;
  assign bf_B = sr[0].vld ? rd_data_b : '0;
  assign bf_W = sr[0].vld ? tw_data : '0;
  assign tap = bf_CT ? sr[LAT_CT] : sr[LAT_GS];
  assign wr_en = tap.vld;
  assign wr_addr_a = tap.a;
  assign wr_addr_b = tap.b;
  assign wr_data_a = wr_en ? bf_E : '0;
  assign wr_data_b = wr_en ? bf_O : '0;

  always_ff @(posedge clk or negedge rst)
    if (!rst) sr <= '0;
    else sr <= {sr[DEPTH-2:0], {rd_en, rd_en && idx == 7'd127, rd_addr_a, rd_addr_b}};

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      layer <= '0;
      idx <= '0;
      bf_CT <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_ISSUE;
          bf_CT <= ~inv;
          layer <= '0;
          idx <= '0;
          busy <= 1'b1;
        end
        S_ISSUE: begin
          idx <= idx + 7'd1;
          if (idx == 7'd127) state <= S_DRAIN;
        end
        // the layer's final write leaves the pipeline; the next layer may read safely after it
        S_DRAIN: if (tap.vld && tap.last) begin
          if (layer == 3'd6) begin
            state <= S_FINISH;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            state <= S_ISSUE;
            layer <= layer + 3'd1;
          end
        end
        S_FINISH: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_butterfly_ctrl.sv
// tb_butterfly_ctrl: checks the controller against NTT loop-nest schedules and RAM/ROM/butterfly models.
module tb_butterfly_ctrl;
  localparam int LAT_CT = 4;
  localparam int LAT_GS = 5;
  localparam int QM = 3329;

  logic clk = 0, rst = 0, start = 0, inv = 0;
  logic busy, done, rd_en, wr_en, bf_CT;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] tw_addr;
  logic [11:0] rd_data_a = '0, rd_data_b = '0, tw_data = '0;
  logic [11:0] bf_A, bf_B, bf_W, bf_E, bf_O, wr_data_a, wr_data_b;

  always #5 clk = ~clk;

  butterfly_ctrl #(.LAT_CT(LAT_CT), .LAT_GS(LAT_GS)) dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .tw_addr(tw_addr), .tw_data(tw_data),
    .bf_CT(bf_CT), .bf_A(bf_A), .bf_B(bf_B), .bf_W(bf_W), .bf_E(bf_E), .bf_O(bf_O),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b)
  );

  // RAM, twiddle ROM and a pipelined butterfly (or a constant stub)
  int mem [256];
  int rom [128];
  int x0 [256];
  int rf [256];
  int pe [5];
  int po [5];
  bit stub = 1;
  bit load = 0;

  function automatic int half(input int x);
    return (x % 2 == 0) ? x / 2 : (x + QM) / 2;
  endfunction

  always @(posedge clk) begin
    int a, b, w, t;
    if (load) for (int i = 0; i < 256; i++) mem[i] <= x0[i];
    if (rd_en) begin
      rd_data_a <= 12'(mem[rd_addr_a]);
      rd_data_b <= 12'(mem[rd_addr_b]);
      tw_data <= 12'(rom[tw_addr]);
    end
    if (wr_en) begin
      mem[wr_addr_a] <= int'(wr_data_a);
      mem[wr_addr_b] <= int'(wr_data_b);
    end
    a = int'(bf_A);
    b = int'(bf_B);
    w = int'(bf_W);
    if (bf_CT) begin
      t = (w * b) % QM;
      pe[0] <= (a + t) % QM;
      po[0] <= (a - t + QM) % QM;
    end else begin
      pe[0] <= half((a + b) % QM);
      po[0] <= half((w * ((b - a + QM) % QM)) % QM);
    end
    for (int k = 1; k < 5; k++) begin
      pe[k] <= pe[k-1];
      po[k] <= po[k-1];
    end
  end

  assign bf_E = stub ? 12'hAAA : 12'(bf_CT ? pe[LAT_CT-1] : pe[LAT_GS-1]);
  assign bf_O = stub ? 12'h555 : 12'(bf_CT ? po[LAT_CT-1] : po[LAT_GS-1]);

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_rd_en"}, rd_en, 0);
    chk({nm, "_wr_en"}, wr_en, 0);
    chk({nm, "_bf_CT"}, bf_CT, 0);
    chk({nm, "_rd_addr"}, {rd_addr_a, rd_addr_b}, 0);
    chk({nm, "_tw_addr"}, tw_addr, 0);
    chk({nm, "_wr_addr"}, {wr_addr_a, wr_addr_b}, 0);
    chk({nm, "_wr_data"}, {wr_data_a, wr_data_b}, 0);
    chk({nm, "_bf_ops"}, int'(bf_A) | int'(bf_B) | int'(bf_W), 0);
  endtask

  // expected schedule per cycle, built from the NTT loop nests
  bit e_rd [1024];
  bit e_wr [1024];
  int e_a [1024], e_b [1024], e_tw [1024], e_wa [1024], e_wb [1024];
  int la [2][896], lb [2][896], lt [2][896];
  int r_done [2], r_first [2], r_wr [2], r_dn [2];

  task automatic run(input bit m, input int spur, input int rst_cyc);
    int lat, per, last, k, n_rd, n_wr, n_done, first, dcyc;
    lat = m ? LAT_GS : LAT_CT;
    per = 129 + lat;
    last = 7 * per;
    k = m ? 127 : 1;
    for (int c = 0; c < 1024; c++) begin
      e_rd[c] = 0; e_wr[c] = 0; e_a[c] = 0; e_b[c] = 0; e_tw[c] = 0; e_wa[c] = 0; e_wb[c] = 0;
    end
    for (int l = 0; l < 7; l++) begin
      int len, n;
      len = m ? 2 << l : 128 >> l;
      n = 0;
      for (int st = 0; st < 256; st += 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          int c;
          c = 1 + l * per + n;
          e_rd[c] = 1; e_a[c] = j; e_b[c] = j + len; e_tw[c] = k;
          e_wr[c+1+lat] = 1; e_wa[c+1+lat] = j; e_wb[c+1+lat] = j + len;
          n++;
        end
        k = m ? k - 1 : k + 1;
      end
    end
    n_rd = 0; n_wr = 0; n_done = 0; first = -1; dcyc = -1;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    inv = m;
    start = 1;
    @(negedge clk);
    start = 0;
    inv = 1'($urandom_range(0, 1));
    for (int c = 1; c <= last + 8; c++) begin
      if (c == rst_cyc) begin
        rst = 0;
        #1;
        check_zero("reset_mid");
        repeat (20) begin
          @(negedge clk);
          chk("rd_en_in_reset", rd_en, 0);
          chk("wr_en_in_reset", wr_en, 0);
        end
        rst = 1;
        repeat (8) begin
          @(negedge clk);
          chk("wr_en_after_reset", wr_en, 0);
          chk("busy_after_reset", busy, 0);
        end
        return;
      end
      chk($sformatf("rd_en c%0d", c), rd_en, e_rd[c]);
      if (e_rd[c]) begin
        chk($sformatf("rd_addr_a c%0d", c), rd_addr_a, e_a[c]);
        chk($sformatf("rd_addr_b c%0d", c), rd_addr_b, e_b[c]);
        chk($sformatf("tw_addr c%0d", c), tw_addr, e_tw[c]);
      end
      if (rd_en && n_rd < 896) begin
        la[m][n_rd] = rd_addr_a; lb[m][n_rd] = rd_addr_b; lt[m][n_rd] = tw_addr;
        n_rd++;
      end
      if (e_rd[c-1]) begin
        chk($sformatf("bf_A c%0d", c), bf_A, rd_data_a);
        chk($sformatf("bf_W c%0d", c), bf_W, tw_data);
      end
      chk($sformatf("wr_en c%0d", c), wr_en, e_wr[c]);
      if (e_wr[c]) begin
        chk($sformatf("wr_addr_a c%0d", c), wr_addr_a, e_wa[c]);
        chk($sformatf("wr_addr_b c%0d", c), wr_addr_b, e_wb[c]);
        if (stub) chk($sformatf("wr_data c%0d", c), {wr_data_a, wr_data_b}, 24'hAAA555);
      end
      if (wr_en) begin
        n_wr++;
        if (first < 0) first = c;
      end
      if (done) begin
        n_done++;
        if (dcyc < 0) dcyc = c;
      end
      chk($sformatf("busy c%0d", c), busy, (c <= last) ? 1 : 0);
      chk($sformatf("bf_CT c%0d", c), bf_CT, m ? 0 : 1);
      start = (c == spur);
      inv = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 0;
    r_done[m] = dcyc; r_first[m] = first; r_wr[m] = n_wr; r_dn[m] = n_done;
  endtask

  task automatic ntt_ref();
    int k, z, t;
    k = 1;
    for (int len = 128; len >= 2; len = len / 2)
      for (int st = 0; st < 256; st += 2 * len) begin
        z = rom[k];
        k++;
        for (int j = st; j < st + len; j++) begin
          t = (z * rf[j+len]) % QM;
          rf[j+len] = (rf[j] - t + QM) % QM;
          rf[j] = (rf[j] + t) % QM;
        end
      end
  endtask

  task automatic e2e(input bit delta);
    for (int i = 0; i < 256; i++) begin
      x0[i] = delta ? (i == 0 ? 1 : 0) : int'($urandom_range(0, QM - 1));
      rf[i] = x0[i];
    end
    ntt_ref();
    @(negedge clk);
    load = 1;
    @(negedge clk);
    load = 0;
    stub = 0;
    run(0, -1, -1);
    for (int i = 0; i < 256; i++) chk($sformatf("ntt[%0d]", i), mem[i], rf[i]);
    run(1, $urandom_range(1, 930), -1);
    for (int i = 0; i < 256; i++) chk($sformatf("intt[%0d]", i), mem[i], x0[i]);
    stub = 1;
  endtask

  typedef struct { bit m; int layer; int issue; int a; int b; int tw; } vec_t;
  typedef struct { bit m; int done_c; int first_wr; int wr_cnt; } run_t;
  vec_t vt [11];
  run_t rt [2];

  initial begin
    vt[0]  = '{0, 0, 0, 0, 128, 1};
    vt[1]  = '{0, 0, 1, 1, 129, 1};
    vt[2]  = '{0, 6, 2, 4, 6, 65};
    vt[3]  = '{0, 1, 64, 128, 192, 3};
    vt[4]  = '{0, 6, 127, 253, 255, 127};
    vt[5]  = '{1, 0, 0, 0, 2, 127};
    vt[6]  = '{1, 0, 1, 1, 3, 127};
    vt[7]  = '{1, 0, 2, 4, 6, 126};
    vt[8]  = '{1, 6, 0, 0, 128, 1};
    vt[9]  = '{1, 6, 127, 127, 255, 1};
    vt[10] = '{1, 0, 127, 253, 255, 64};
    rt[0] = '{0, 932, 6, 896};
    rt[1] = '{1, 939, 7, 896};
    for (int k = 0; k < 128; k++) begin
      int r, z;
      r = 0;
      for (int b = 0; b < 7; b++) r |= ((k >> b) & 1) << (6 - b);
      z = 1;
      repeat (r) z = (z * 17) % QM;
      rom[k] = z;
    end
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1;
    run(0, 100, -1);
    run(1, $urandom_range(1, 930), -1);
    for (int v = 0; v < 11; v++) begin
      int ix;
      ix = vt[v].layer * 128 + vt[v].issue;
      chk($sformatf("vec%0d_a", v), la[vt[v].m][ix], vt[v].a);
      chk($sformatf("vec%0d_b", v), lb[vt[v].m][ix], vt[v].b);
      chk($sformatf("vec%0d_tw", v), lt[vt[v].m][ix], vt[v].tw);
    end
    for (int r = 0; r < 2; r++) begin
      chk($sformatf("run%0d_done_cycle", r), r_done[rt[r].m], rt[r].done_c);
      chk($sformatf("run%0d_done_count", r), r_dn[rt[r].m], 1);
      chk($sformatf("run%0d_first_wr", r), r_first[rt[r].m], rt[r].first_wr);
      chk($sformatf("run%0d_wr_count", r), r_wr[rt[r].m], rt[r].wr_cnt);
    end
    run(0, -1, 50);
    run(0, $urandom_range(1, 930), -1);
    chk("rerun_done_cycle", r_done[0], rt[0].done_c);
    chk("rerun_done_count", r_dn[0], 1);
    chk("rerun_wr_count", r_wr[0], rt[0].wr_cnt);
    e2e(1);
    e2e(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
